// File: rtl/lcd_display_cpu_jtag_debug_host.sv
// lcd_display_cpu_jtag_debug_host: virtual-JTAG sequencer issuing one IR select plus one DR scan per command
module lcd_display_cpu_jtag_debug_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);
    localparam logic [2:0] IDLE = 3'd0, UIR = 3'd1, CDR = 3'd2, SDR = 3'd3, UDR = 3'd4, DONE = 3'd5;
    logic [2:0]          state;
    logic [7:0]          div_cnt;
    logic [6:0]          bit_cnt;
    logic [DR_WIDTH-1:0] sr;
    logic                run, term, rise, fall;
    assign run            = state inside {UIR, CDR, SDR, UDR};
    assign term           = run && div_cnt == 8'(TCK_DIV - 1);
    assign rise           = term && !tck;
    assign fall           = term && tck;
    assign cmd_ready      = state == IDLE;
    assign rsp_valid      = state == DONE;
    assign jtag_state_rti = state == IDLE || state == DONE;
    assign vs_uir         = state == UIR;
    assign vs_cdr         = state == CDR;
    assign vs_sdr         = state == SDR;
    assign vs_udr         = state == UDR;
    // tck divider, scan sequencing and response capture; all moves happen on divider ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sr         <= '0;
            tck        <= 1'b0;
            tdi        <= 1'b0;
            ir_in      <= '0;
            rsp_dr     <= '0;
            rsp_ir_out <= '0;
        end else begin
            div_cnt <= (term || !run) ? 8'd0 : div_cnt + 8'd1;
            if (term) tck <= !tck;
            case (state)
                IDLE: if (cmd_valid) begin
                    sr    <= cmd_dr;
                    ir_in <= cmd_ir;
                    state <= UIR;
                end
                UIR: if (fall) state <= CDR;
                CDR: begin
                    if (rise) rsp_ir_out <= ir_out;
                    if (fall) begin
                        state   <= SDR;
                        tdi     <= sr[0];
                        bit_cnt <= '0;
                    end
                end
                SDR: begin
                    if (rise) begin
                        sr      <= {tdo, sr[DR_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 7'd1;
                    end
                    if (fall) begin
                        if (bit_cnt == 7'(DR_WIDTH)) state <= UDR;
                        else tdi <= sr[0];
                    end
                end
                UDR: if (fall) begin
                    state  <= DONE;
                    rsp_dr <= sr;
                end
                DONE: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_display_cpu_jtag_debug_host.sv
// tb_lcd_display_cpu_jtag_debug_host: self-checking bench with loopback target model
module tb_lcd_display_cpu_jtag_debug_host;
    logic        clk = 0, reset = 1;
    logic        cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0;
    logic [1:0]  cmd_ir = 0, rsp_ir_out, ir_in, ir_out = 0;
    logic [37:0] cmd_dr = 0, rsp_dr;
    logic        tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, rti;
    logic        loop = 0, tdo_c = 0, tgt_load = 0;
    logic [37:0] tgt = 0, tgt_preset = 0;
    logic        c1_valid = 0, c1_ready, r1_valid, r1_ready = 0, tck1, tdi1, tdo1 = 0;
    logic [1:0]  c1_ir = 0, r1_ir, ir1_in, ir1_out = 0;
    logic [1:0]  c1_dr = 0, r1_dr;
    logic        u1_uir, u1_cdr, u1_sdr, u1_udr, rti1;
    int          errors = 0, checks = 0;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] dr;
        logic [37:0] preset;
        logic [1:0]  irout;
        logic [37:0] exp_dr;
        logic [37:0] exp_tgt;
        logic [1:0]  exp_ir;
    } tv_t;

    always #5 clk = ~clk;
    assign tdo = loop ? tgt[0] : tdo_c;

    // target scan register: shifts on tck rising while in SDR, tdi enters at the MSB
    always @(posedge tck or posedge tgt_load)
        if (tgt_load) tgt <= tgt_preset;
        else if (vs_sdr) tgt <= {tdi, tgt[37:1]};

    lcd_display_cpu_jtag_debug_host u0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .tck(tck), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
        .vs_udr(vs_udr), .jtag_state_rti(rti));

    lcd_display_cpu_jtag_debug_host #(.DR_WIDTH(2), .IR_WIDTH(2), .TCK_DIV(1)) u1 (
        .clk(clk), .reset(reset), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
        .cmd_ir(c1_ir), .cmd_dr(c1_dr), .rsp_valid(r1_valid), .rsp_ready(r1_ready),
        .rsp_dr(r1_dr), .rsp_ir_out(r1_ir), .tck(tck1), .tdi(tdi1), .tdo(tdo1),
        .ir_in(ir1_in), .ir_out(ir1_out), .vs_uir(u1_uir), .vs_cdr(u1_cdr), .vs_sdr(u1_sdr),
        .vs_udr(u1_udr), .jtag_state_rti(rti1));

    task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    task automatic preset_tgt(input logic [37:0] v);
        tgt_preset = v;
        tgt_load = 1;
        #1 tgt_load = 0;
    endtask

    task automatic do_cmd(input logic [1:0] ir, input logic [37:0] dr);
        int cyc, k, first, uir_bad, tdi_bad, stab_bad;
        logic pt, pd;
        @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1; cmd_ir = ir; cmd_dr = dr;
        @(posedge clk); #1;
        cmd_valid = 0;
        cyc = 0; k = 0; first = 0; uir_bad = 0; tdi_bad = 0; stab_bad = 0;
        pt = tck; pd = tdi;
        while (!rsp_valid && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (tck && !pt) begin
                if (first == 0) first = cyc;
                if (vs_sdr) begin
                    if (tdi !== pd) stab_bad++;
                    if (k < 38 && tdi !== dr[k]) tdi_bad++;
                    k++;
                end
            end
            if (vs_uir && ir_in !== ir) uir_bad++;
            pt = tck; pd = tdi;
        end
        check("latency", 64'(cyc), 64'd328);
        check("first_rise", 64'(first), 64'd4);
        check("sdr_rises", 64'(k), 64'd38);
        check("ir_in_uir", 64'(uir_bad), 64'd0);
        check("tdi_value", 64'(tdi_bad), 64'd0);
        check("tdi_stable", 64'(stab_bad), 64'd0);
    endtask

    task automatic accept_rsp;
        @(negedge clk); rsp_ready = 1;
        @(posedge clk); #1;
        check("rsp_drop", 64'(rsp_valid), 64'd0);
        check("back_idle", 64'(cmd_ready), 64'd1);
        rsp_ready = 0;
    endtask

    initial begin
        tv_t tv[4];
        logic [37:0] r, d, p;
        logic [1:0]  ri, ro;
        int bad, k, cyc, tog;
        tv[0] = '{2'b01, 38'h01_2345_6789, 38'h2A_DEAD_BEEF, 2'b01, 38'h2A_DEAD_BEEF, 38'h01_2345_6789, 2'b01};
        tv[1] = '{2'b11, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 2'b00, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 2'b00};
        tv[2] = '{2'b10, 38'h00_0000_0001, 38'h20_0000_0000, 2'b11, 38'h20_0000_0000, 38'h00_0000_0001, 2'b11};
        tv[3] = '{2'b00, 38'h2A_AAAA_AAAA, 38'h15_5555_5555, 2'b01, 38'h15_5555_5555, 38'h2A_AAAA_AAAA, 2'b01};
        repeat (3) @(posedge clk);
        #1;
        check("rst_tck", 64'(tck), 64'd0);
        check("rst_strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'd0);
        check("rst_rti_ready", 64'({rti, cmd_ready, rsp_valid}), 64'b110);
        check("rst_rsp", 64'({rsp_dr, rsp_ir_out, ir_in, tdi}), 64'd0);
        @(negedge clk); reset = 0;

        tdo_c = 1; ir_out = 2'b10;
        do_cmd(2'b01, 38'h15_5555_5555);
        check("t1_rsp_dr", 64'(rsp_dr), 64'h3F_FFFF_FFFF);
        check("t1_ir_out", 64'(rsp_ir_out), 64'd2);
        check("t1_tck_low", 64'(tck), 64'd0);
        r = rsp_dr; bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cmd_valid = (i == 20); cmd_ir = 2'b11;
            @(posedge clk); #1;
            if (!rsp_valid || rsp_dr !== r || cmd_ready || tck) bad++;
        end
        cmd_valid = 0;
        check("hold_stable", 64'(bad), 64'd0);
        check("hold_ir_in", 64'(ir_in), 64'd1);
        accept_rsp();

        loop = 1;
        for (int i = 0; i < 4; i++) begin
            preset_tgt(tv[i].preset);
            ir_out = tv[i].irout;
            do_cmd(tv[i].ir, tv[i].dr);
            check("tv_rsp_dr", 64'(rsp_dr), 64'(tv[i].exp_dr));
            check("tv_tgt", 64'(tgt), 64'(tv[i].exp_tgt));
            check("tv_ir_out", 64'(rsp_ir_out), 64'(tv[i].exp_ir));
            accept_rsp();
        end

        for (int i = 0; i < 3; i++) begin
            d = 38'({$urandom, $urandom});
            p = 38'({$urandom, $urandom});
            ri = 2'($urandom); ro = 2'($urandom);
            preset_tgt(p);
            ir_out = ro;
            do_cmd(ri, d);
            check("rnd_rsp_dr", 64'(rsp_dr), 64'(p));
            check("rnd_tgt", 64'(tgt), 64'(d));
            check("rnd_ir_out", 64'(rsp_ir_out), 64'(ro));
            check("rnd_ir_in", 64'(ir_in), 64'(ri));
            accept_rsp();
        end

        preset_tgt(38'h2A_DEAD_BEEF);
        @(negedge clk); cmd_valid = 1; cmd_ir = 2'b10; cmd_dr = 38'h12_3456_789A;
        @(posedge clk); #1; cmd_valid = 0;
        k = 0; cyc = 0;
        while (k < 10 && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
            if (vs_sdr && tck && (u0.div_cnt == 0)) k++;
        end
        check("abort_reach", 64'(k), 64'd10);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        check("abort_tck", 64'(tck), 64'd0);
        check("abort_strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'd0);
        check("abort_rti_ready", 64'({rti, cmd_ready, rsp_valid}), 64'b110);
        check("abort_regs", 64'({rsp_dr, rsp_ir_out, ir_in, tdi}), 64'd0);
        @(negedge clk); reset = 0;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || !cmd_ready) bad++;
        end
        check("abort_no_rsp", 64'(bad), 64'd0);
        preset_tgt(38'h0B_CAFE_F00D);
        ir_out = 2'b01;
        do_cmd(2'b11, 38'h30_0F0F_0F0F);
        check("post_rsp_dr", 64'(rsp_dr), 64'h0B_CAFE_F00D);
        check("post_tgt", 64'(tgt), 64'h30_0F0F_0F0F);
        accept_rsp();

        for (int t = 0; t < 2; t++) begin
            tdo1 = t[0];
            @(negedge clk); c1_valid = 1; c1_ir = 2'b01; c1_dr = 2'b10;
            @(posedge clk); #1; c1_valid = 0;
            cyc = 0; tog = 0; r[0] = tck1;
            while (!r1_valid && cyc < 100) begin
                @(posedge clk); #1; cyc++;
                if (tck1 !== r[0]) tog++;
                r[0] = tck1;
            end
            check("u1_latency", 64'(cyc), 64'd10);
            check("u1_toggles", 64'(tog), 64'd10);
            check("u1_rsp_dr", 64'(r1_dr), t == 0 ? 64'd0 : 64'd3);
            @(negedge clk); r1_ready = 1;
            @(posedge clk); #1; r1_ready = 0;
            check("u1_idle", 64'({r1_valid, c1_ready}), 64'b01);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
